imem_fetch_sequencer: RTL
=========================

Name: imem_fetch_sequencer

Overview:
Fetch controller that sequences the read-only instruction memory for the processor. Holds the program counter and drives the 64-bit memory address. Waits a fixed, parameterised read latency, then captures the 32-bit instruction word and presents it to decode over a valid/ready handshake. Accepts branch redirects (CBZ/B targets) that flush the in-flight fetch. Stops at a program-limit address.

Parameters:
RD_LATENCY, 2, clocks from a stable ImemAddress to a valid ImemData; legal range 1..15
PC_LIMIT, 64'h060, first byte address not fetched; reaching it halts the sequencer
CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > RD_LATENCY

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse; begin fetching at StartPC (honoured only in IDLE or HALT)
StartPC  input  64  initial fetch address
ImemAddress  output  64  address to instruction memory
ImemData  input  32  instruction word from memory
Instr  output  32  captured instruction
InstrPC  output  64  address of Instr
InstrValid  output  1  Instr/InstrPC valid
InstrReady  input  1  decode accepts Instr this cycle
RedirectValid  input  1  branch taken; refetch from RedirectPC
RedirectPC  input  64  branch target
Halted  output  1  PC reached PC_LIMIT
Busy  output  1  high in WAIT or OUT

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. All state is registered; outputs come straight from registers.
- Reset values:
  - state=IDLE, pc=0, ImemAddress=0, Instr=0, InstrPC=0.
  - InstrValid=0, Halted=0, Busy=0, counter=0.
- ImemAddress always equals pc.
- States and transitions:
  - IDLE: on Start, load pc=StartPC with bits[1:0] forced to 0 and counter=RD_LATENCY, then go to WAIT. If StartPC>=PC_LIMIT, go to HALT instead.
  - WAIT: decrement counter each cycle. On the edge where counter==1, capture Instr=ImemData and InstrPC=pc, set InstrValid=1, and go to OUT. Result: InstrValid rises exactly RD_LATENCY cycles after pc is loaded. ImemData is captured verbatim, X included.
  - OUT: while InstrValid && !InstrReady, hold Instr, InstrPC and InstrValid stable. On a handshake (InstrValid && InstrReady), pc=pc+4 and InstrValid=0. Then:
    - if pc+4 >= PC_LIMIT, go to HALT;
    - otherwise load counter=RD_LATENCY and go to WAIT.
  - HALT: Halted=1, InstrValid=0, pc held. Start restarts exactly as from IDLE and clears Halted.
- Redirect:
  - RedirectValid is sampled in WAIT, OUT and HALT. It overrides every other transition except reset.
  - Action: pc=RedirectPC with bits[1:0] forced to 0, counter=RD_LATENCY, InstrValid=0 next cycle, Halted=0, go to WAIT. Any partially counted fetch is discarded.
  - If the target is >= PC_LIMIT, go to HALT (Halted=1).
  - Redirect in the same cycle as a handshake: the handshaken instruction counts as consumed, and the redirect target wins over pc+4.
  - RedirectValid in IDLE is ignored.
- Start while in WAIT or OUT is ignored.
- pc+4 arithmetic is 64-bit unsigned and wraps modulo 2^64. PC_LIMIT comparison is unsigned.
- Reset asserted mid-fetch returns all state to the reset values immediately (asynchronously). No instruction is emitted after reset until the next Start.
- Busy = (state==WAIT) || (state==OUT).
- Throughput: one instruction per RD_LATENCY+1 cycles when InstrReady is held high.

Test Plan:
- Reset, RD_LATENCY=2, Start with StartPC=0, InstrReady=1 -> InstrValid pulses with InstrPC=0x00, 0x04, 0x08… every 3 cycles; Instr at 0x00 = F84003E9, at 0x014 = AA0B014A.
- Run to PC_LIMIT=0x060 -> last handshake at InstrPC=0x05C, then Halted=1 and InstrValid=0 permanently; a new Start with StartPC=0x034 restarts, and the first Instr is CB090129.
- InstrReady=0 for 5 cycles at InstrPC=0x01C -> Instr and InstrPC stable for all 5 cycles; the first handshake then advances to InstrPC=0x020.
- RedirectValid with RedirectPC=0x01C in the same cycle as the handshake of 0x028 -> next InstrValid carries InstrPC=0x01C, not 0x02C, RD_LATENCY cycles later.
- Redirect mid-WAIT with RedirectPC=0x02E -> pc becomes 0x02C; the in-flight word is never presented; next InstrPC=0x02C with Instr F80203ED.
- Reset asserted in OUT with InstrValid=1 -> InstrValid, ImemAddress and Busy go to 0 without waiting for a clock edge; no output until Start.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: sequences instruction-memory reads and hands words to decode over valid/ready
module imem_fetch_sequencer #(
    parameter int unsigned  RD_LATENCY = 2,
    parameter logic [63:0]  PC_LIMIT   = 64'h060,
    parameter int unsigned  CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [63:0] StartPC,
    output logic [63:0] ImemAddress,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        RedirectValid,
    input  logic [63:0] RedirectPC,
    output logic        Halted,
    output logic        Busy
);
    typedef enum logic [1:0] {IDLE, WAIT, OUT, HALT} state_t;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);
    state_t           state;
    logic [63:0]      pc;
    logic [CNT_W-1:0] cnt;
    logic             redirect_hit;
    logic             start_hit;
    logic             handshake;
    logic             load;
    logic             load_halt;
    logic [63:0]      load_src;
    assign ImemAddress = pc;
    // a new fetch address comes from a redirect, a start, or the handshake of the current word (in that priority)
    always_comb begin
        redirect_hit = RedirectValid && state != IDLE;
        start_hit    = Start && (state == IDLE || state == HALT);
        handshake    = state == OUT && InstrValid && InstrReady;
        load         = redirect_hit || start_hit || handshake;
        load_src     = redirect_hit ? RedirectPC : start_hit ? StartPC : pc + 64'd4;
        load_halt    = load_src >= PC_LIMIT;
    end
    // sequencer state: reload restarts the latency count, WAIT counts down and captures the memory word
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= '0;
            cnt        <= '0;
            Instr      <= '0;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
            Halted     <= 1'b0;
            Busy       <= 1'b0;
        end else if (load) begin
            pc         <= {load_src[63:2], 2'b00};
            cnt        <= LAT;
            InstrValid <= 1'b0;
            Halted     <= load_halt;
            Busy       <= !load_halt;
            state      <= load_halt ? HALT : WAIT;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                Instr      <= ImemData;
                InstrPC    <= pc;
                InstrValid <= 1'b1;
                state      <= OUT;
            end
        end
    end
endmodule
